// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing the exec-unit RAM port between fetch (IF) and load/store (LS).
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is LS priority with IF starvation guard.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              rd_ram_en,
  output logic [ADDR_W-1:0] rd_ram_addr,
  input  logic [DATA_W-1:0] rd_ram_data,
  output logic              wr_ram_en,
  output logic [ADDR_W-1:0] wr_ram_addr,
  output logic [DATA_W-1:0] wr_ram_data,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_DONE} state_t;

  state_t     state_q;
  logic [2:0] lat_q;
  logic       owner_q;   // 1 = LS owns the outstanding transaction
  logic       arb_d;
  logic       if_wins_d;

  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] a);
    return a & ~{{(ADDR_W-2){1'b0}}, 2'b11};
  endfunction

  assign arb_d = (state_q == IDLE) && (if_req || ls_req);

`ifdef ARB_ROUND_ROBIN_EN
  logic last_ls_q;

  always_comb begin
    if_wins_d = if_req && (!ls_req || last_ls_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_ls_q <= 1'b1;
    end else if (arb_d) begin
      last_ls_q <= !if_wins_d;
    end
  end
`else
  logic [3:0] starve_q;

  always_comb begin
    if_wins_d = if_req && (!ls_req || (starve_q == 4'(STARVE_LIMIT)));
  end

  // Saturating count of consecutive arbitrations IF lost to LS.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_q <= 4'd0;
    end else if (arb_d) begin
      if (if_wins_d) begin
        starve_q <= 4'd0;
      end else if (if_req && (starve_q != 4'(STARVE_LIMIT))) begin
        starve_q <= starve_q + 4'd1;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      lat_q       <= 3'd0;
      owner_q     <= 1'b0;
      if_gnt      <= 1'b0;
      if_rvalid   <= 1'b0;
      if_rdata    <= '0;
      ls_gnt      <= 1'b0;
      ls_rvalid   <= 1'b0;
      ls_rdata    <= '0;
      rd_ram_en   <= 1'b0;
      rd_ram_addr <= '0;
      wr_ram_en   <= 1'b0;
      wr_ram_addr <= '0;
      wr_ram_data <= '0;
      busy        <= 1'b0;
    end else begin
      if_gnt    <= 1'b0;
      ls_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      rd_ram_en <= 1'b0;
      wr_ram_en <= 1'b0;
      case (state_q)
        IDLE: begin
          if (arb_d) begin
            owner_q <= !if_wins_d;
            busy    <= 1'b1;
            if (if_wins_d) begin
              if_gnt      <= 1'b1;
              rd_ram_en   <= 1'b1;
              rd_ram_addr <= word_addr(if_addr);
              lat_q       <= 3'(RD_LATENCY);
              state_q     <= RD_WAIT;
            end else begin
              ls_gnt <= 1'b1;
              if (ls_we) begin
                wr_ram_en   <= 1'b1;
                wr_ram_addr <= word_addr(ls_addr);
                wr_ram_data <= ls_wdata;
                state_q     <= WR_DONE;
              end else begin
                rd_ram_en   <= 1'b1;
                rd_ram_addr <= word_addr(ls_addr);
                lat_q       <= 3'(RD_LATENCY);
                state_q     <= RD_WAIT;
              end
            end
          end
        end
        RD_WAIT: begin
          // Counter reaches zero in the cycle the RAM data is valid.
          if (lat_q == 3'd0) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            if (owner_q) begin
              ls_rvalid <= 1'b1;
              ls_rdata  <= rd_ram_data;
            end else begin
              if_rvalid <= 1'b1;
              if_rdata  <= rd_ram_data;
            end
          end else begin
            lat_q <= lat_q - 3'd1;
          end
        end
        WR_DONE: begin
          ls_rvalid <= 1'b1;
          ls_rdata  <= '0;
          state_q   <= IDLE;
          busy      <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: RD_LATENCY=1 instance for function, RD_LATENCY=3 instance for mid-read reset.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, rst3_n;
  logic        if_req, ls_req, ls_we;
  logic [31:0] if_addr, ls_addr, ls_wdata;

  logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, rd_ram_en, wr_ram_en, busy;
  logic [31:0] if_rdata, ls_rdata, rd_ram_addr, rd_ram_data, wr_ram_addr, wr_ram_data;

  logic        if_gnt3, if_rvalid3, ls_gnt3, ls_rvalid3, rd_ram_en3, wr_ram_en3, busy3;
  logic [31:0] if_rdata3, ls_rdata3, rd_ram_addr3, rd_ram_data3, wr_ram_addr3, wr_ram_data3;

  int checks   = 0;
  int failures = 0;

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'hDEAD_BEEF;
    return a ^ 32'hC0DE_0000;
  endfunction

  // RAM models: one-cycle and three-cycle read pipelines
  logic [31:0] ram_q, ram3_a, ram3_b, ram3_c;
  always @(posedge clk) begin
    ram_q  <= ram_word(rd_ram_addr);
    ram3_a <= ram_word(rd_ram_addr3);
    ram3_b <= ram3_a;
    ram3_c <= ram3_b;
  end
  assign rd_ram_data  = ram_q;
  assign rd_ram_data3 = ram3_c;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(1), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .rd_ram_en(rd_ram_en), .rd_ram_addr(rd_ram_addr), .rd_ram_data(rd_ram_data),
    .wr_ram_en(wr_ram_en), .wr_ram_addr(wr_ram_addr), .wr_ram_data(wr_ram_data),
    .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(3), .STARVE_LIMIT(4)) dut3 (
    .clk(clk), .reset_n(rst3_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt3), .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt3), .ls_rvalid(ls_rvalid3), .ls_rdata(ls_rdata3),
    .rd_ram_en(rd_ram_en3), .rd_ram_addr(rd_ram_addr3), .rd_ram_data(rd_ram_data3),
    .wr_ram_en(wr_ram_en3), .wr_ram_addr(wr_ram_addr3), .wr_ram_data(wr_ram_data3),
    .busy(busy3)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          ng, ovl, rv;
    logic [5:0]  seq;
    logic [5:0]  seq_exp;

    reset_n  = 1'b0;
    rst3_n   = 1'b0;
    if_req   = 1'b0;
    ls_req   = 1'b0;
    ls_we    = 1'b0;
    if_addr  = 32'h0;
    ls_addr  = 32'h0;
    ls_wdata = 32'h0;
    step();
    step();
    check_eq("rst_ctrl", 32'({if_gnt, ls_gnt, if_rvalid, ls_rvalid, rd_ram_en, wr_ram_en, busy}), 32'h0);
    check_eq("rst_rd_addr", rd_ram_addr, 32'h0);
    check_eq("rst_wr_addr", wr_ram_addr | wr_ram_data, 32'h0);
    check_eq("rst_rdata", if_rdata | ls_rdata, 32'h0);
    reset_n = 1'b1;
    step();
    check_eq("idle_busy", 32'(busy), 32'h0);

    // IF-only read of 0x10
    if_addr = 32'h0000_0010;
    if_req  = 1'b1;
    step();
    check_eq("t1_c1_gnt", 32'({if_gnt, ls_gnt}), 32'h2);
    check_eq("t1_c1_rden", 32'(rd_ram_en), 32'h1);
    check_eq("t1_c1_addr", rd_ram_addr, 32'h10);
    check_eq("t1_c1_busy", 32'(busy), 32'h1);
    if_req = 1'b0;
    step();
    check_eq("t1_c2_ctrl", 32'({if_gnt, rd_ram_en, if_rvalid, busy}), 32'h1);
    step();
    check_eq("t1_c3_rvalid", 32'({if_rvalid, ls_rvalid, busy}), 32'h4);
    check_eq("t1_c3_rdata", if_rdata, 32'hDEAD_BEEF);
    step();
    check_eq("t1_c4_rvalid", 32'(if_rvalid), 32'h0);
    check_eq("t1_c4_hold", if_rdata, 32'hDEAD_BEEF);

    // Simultaneous requests: LS read 0x100 first, then IF read 0x22 -> 0x20
    ls_addr = 32'h0000_0100;
    ls_we   = 1'b0;
    ls_req  = 1'b1;
    if_addr = 32'h0000_0022;
    if_req  = 1'b1;
    step();
    check_eq("t3_c1_gnt", 32'({if_gnt, ls_gnt}), 32'h1);
    check_eq("t3_c1_addr", rd_ram_addr, 32'h100);
    ls_req = 1'b0;
    step();
    check_eq("t3_c2_gnt", 32'({if_gnt, ls_gnt}), 32'h0);
    step();
    check_eq("t3_c3_rvalid", 32'({if_rvalid, ls_rvalid, if_gnt}), 32'h2);
    check_eq("t3_c3_rdata", ls_rdata, 32'hC0DE_0100);
    step();
    check_eq("t3_c4_gnt", 32'({if_gnt, ls_gnt}), 32'h2);
    check_eq("t3_c4_addr", rd_ram_addr, 32'h20);
    if_req = 1'b0;
    step();
    step();
    check_eq("t3_c6_rvalid", 32'({if_rvalid, ls_rvalid}), 32'h2);
    check_eq("t3_c6_rdata", if_rdata, 32'hC0DE_0020);
    check_eq("t3_c6_lshold", ls_rdata, 32'hC0DE_0100);

    // LS write to 0x43 -> word 0x40
    ls_addr  = 32'h0000_0043;
    ls_wdata = 32'h1234_5678;
    ls_we    = 1'b1;
    ls_req   = 1'b1;
    step();
    check_eq("t2_c1_ctrl", 32'({ls_gnt, wr_ram_en, rd_ram_en, busy}), 32'hD);
    check_eq("t2_c1_addr", wr_ram_addr, 32'h40);
    check_eq("t2_c1_data", wr_ram_data, 32'h1234_5678);
    ls_req = 1'b0;
    ls_we  = 1'b0;
    step();
    check_eq("t2_c2_ctrl", 32'({ls_rvalid, wr_ram_en, rd_ram_en, busy}), 32'h8);
    check_eq("t2_c2_rdata", ls_rdata, 32'h0);
    step();
    check_eq("t2_c3_rvalid", 32'({ls_rvalid, rd_ram_en}), 32'h0);

    // Both ports requesting continuously: record who wins six arbitrations
    ls_addr = 32'h0000_0200;
    ls_req  = 1'b1;
    if_addr = 32'h0000_0300;
    if_req  = 1'b1;
    ng  = 0;
    ovl = 0;
    seq = 6'b0;
    for (int c = 0; c < 60 && ng < 6; c++) begin
      step();
      if ((if_gnt && ls_gnt) || (if_rvalid && ls_rvalid)) ovl++;
      if (if_gnt || ls_gnt) begin
        seq[ng] = if_gnt;
        ng++;
      end
    end
`ifdef ARB_ROUND_ROBIN_EN
    seq_exp = 6'b010101;
`else
    seq_exp = 6'b010000;
`endif
    check_eq("arb_ngrants", 32'(ng), 32'd6);
    check_eq("arb_seq", 32'(seq), 32'(seq_exp));
    check_eq("arb_overlap", 32'(ovl), 32'd0);
    ls_req = 1'b0;
    if_req = 1'b0;
    repeat (4) step();
    check_eq("arb_idle", 32'(busy), 32'h0);

    // RD_LATENCY=3 instance: reset in RD_WAIT, then a clean read
    rst3_n = 1'b1;
    step();
    if_addr = 32'h0000_0030;
    if_req  = 1'b1;
    step();
    check_eq("t5_c1_gnt", 32'({if_gnt3, busy3}), 32'h3);
    if_req = 1'b0;
    step();
    check_eq("t5_c2_busy", 32'(busy3), 32'h1);
    #2;
    rst3_n = 1'b0;
    #1;
    check_eq("t5_rst_ctrl", 32'({if_gnt3, ls_gnt3, if_rvalid3, ls_rvalid3, rd_ram_en3, wr_ram_en3, busy3}), 32'h0);
    check_eq("t5_rst_addr", rd_ram_addr3 | if_rdata3, 32'h0);
    @(posedge clk);
    #3;
    rst3_n = 1'b1;
    rv = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (if_rvalid3 || ls_rvalid3) rv++;
    end
    check_eq("t5_no_rvalid", 32'(rv), 32'd0);
    if_addr = 32'h0000_0034;
    if_req  = 1'b1;
    step();
    check_eq("t5b_c1_gnt", 32'(if_gnt3), 32'h1);
    check_eq("t5b_c1_addr", rd_ram_addr3, 32'h34);
    if_req = 1'b0;
    step();
    step();
    step();
    check_eq("t5b_c4_rvalid", 32'({if_rvalid3, busy3}), 32'h1);
    step();
    check_eq("t5b_c5_rvalid", 32'({if_rvalid3, busy3}), 32'h2);
    check_eq("t5b_c5_rdata", if_rdata3, 32'hC0DE_0034);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
